// File: rtl/pl_ex_pkg.sv
// Shared definitions for the PL_EX_MC execute stage:
// opcodes, FSM encoding and the default RNS moduli.
package pl_ex_pkg;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_MUL  = 3'd2;
  localparam logic [2:0] OP_PASS = 3'd3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

  // Domain 0 in the LSBs.
  localparam logic [17:0] DEF_MODULI = {9'd256, 9'd251};

endpackage

// File: rtl/pl_modmul_seq.sv
// One RNS domain of the shift-add modular multiplier.
// Iterates MSB-first: acc <= (2*acc + b[k]*a) mod m.
module pl_modmul_seq
  import pl_ex_pkg::*;
#(
  parameter int               DATA_WID = 8,
  parameter logic [DATA_WID:0] MODULUS = 9'd251
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                step,
  input  logic                int_mode,
  input  logic [DATA_WID-1:0] a,
  input  logic [DATA_WID-1:0] b,
  output logic [DATA_WID-1:0] acc
);

  localparam int W = DATA_WID;

  logic [W-1:0] r_a;
  logic [W-1:0] r_b;
  logic [W-1:0] r_acc;
  logic         r_int;

  logic [W+1:0] w_m;
  logic [W+1:0] w_dbl;
  logic [W+1:0] w_t;
  logic [W+1:0] w_sum;
  logic [W+1:0] w_red;
  logic [1:0]   w_unused;

  // Integer mode reuses the datapath with m = 2^W.
  assign w_m   = r_int ? {2'b01, {W{1'b0}}}
                       : {1'b0, MODULUS};
  assign w_dbl = {1'b0, r_acc, 1'b0};
  assign w_t   = (w_dbl >= w_m) ? w_dbl - w_m : w_dbl;
  assign w_sum = w_t + (r_b[W-1] ? {2'b00, r_a}
                                 : {(W+2){1'b0}});
  assign w_red = (w_sum >= w_m) ? w_sum - w_m : w_sum;

  // acc is the value the accumulator takes on this step.
  assign acc      = w_red[W-1:0];
  assign w_unused = w_red[W+1:W];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_a   <= '0;
      r_b   <= '0;
      r_acc <= '0;
      r_int <= 1'b0;
    end else if (start) begin
      r_a   <= a;
      r_b   <= b;
      r_acc <= '0;
      r_int <= int_mode;
    end else if (step) begin
      r_acc <= acc;
      r_b   <= r_b << 1;
    end
  end

endmodule

// File: rtl/pl_ex_mc.sv
// Multi-cycle RNS execute stage: 1-cycle ADD/SUB/PASS,
// DATA_WID-cycle sequential modular MUL, valid/ready output.
module pl_ex_mc
  import pl_ex_pkg::*;
#(
  parameter int NUM_DOMAINS = 2,
  parameter int DATA_WID    = 8,
  parameter logic [NUM_DOMAINS*(DATA_WID+1)-1:0] MODULI
    = DEF_MODULI
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [2:0]                      op,
  input  logic                            rns_en,
  input  logic [NUM_DOMAINS*DATA_WID-1:0] op1,
  input  logic [NUM_DOMAINS*DATA_WID-1:0] op2,
  input  logic [3:0]                      dest_addr,
  input  logic                            flush,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [NUM_DOMAINS*DATA_WID-1:0] out_result,
  output logic [3:0]                      out_dest_addr,
  output logic                            out_cout,
  output logic                            busy
);

  localparam int W  = DATA_WID;
  localparam int N  = NUM_DOMAINS;
  localparam int DW = N * W;
  localparam int CW = $clog2(W + 1);

  state_t        r_state;
  state_t        w_state_nxt;
  logic [CW-1:0] r_cnt;
  logic          r_rns;
  logic [3:0]    r_dest;

  logic w_is_mul;
  logic w_accept;
  logic w_start;
  logic w_step;
  logic w_done;

  logic [W-1:0]  w_add [N];
  logic [W-1:0]  w_sub [N];
  logic [W-1:0]  w_mul [N];
  logic [W:0]    w_isum;
  logic [W:0]    w_idif;
  logic [DW-1:0] w_res_sc;
  logic [DW-1:0] w_res_mul;
  logic          w_cout_sc;

  assign w_is_mul = (op == OP_MUL);
  assign in_ready = (r_state == ST_IDLE)
                 && (!out_valid || out_ready);
  assign w_accept = in_valid && in_ready && !flush;
  assign w_start  = w_accept && w_is_mul;
  assign busy     = (r_state == ST_MUL);

  always_comb begin
    w_state_nxt = r_state;
    w_step      = 1'b0;
    w_done      = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_start) w_state_nxt = ST_MUL;
      end
      ST_MUL: begin
        if (flush) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_step = 1'b1;
          if (r_cnt == CW'(W - 1)) begin
            w_done      = 1'b1;
            w_state_nxt = ST_IDLE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_rns   <= 1'b0;
      r_dest  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_start) begin
        r_cnt  <= '0;
        r_rns  <= rns_en;
        r_dest <= dest_addr;
      end else if (w_step) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  for (genvar i = 0; i < N; i++) begin : g_dom
    localparam logic [W:0] M = MODULI[i*(W+1) +: W+1];

    logic [W-1:0] w_a;
    logic [W-1:0] w_b;
    logic [W:0]   w_s;

    assign w_a = op1[i*W +: W];
    assign w_b = op2[i*W +: W];
    assign w_s = {1'b0, w_a} + {1'b0, w_b};

    // Results are below m <= 2^W, so W-bit wrap is exact.
    assign w_add[i] = (w_s >= M) ? w_a + w_b - M[W-1:0]
                                 : w_a + w_b;
    assign w_sub[i] = (w_a < w_b) ? w_a - w_b + M[W-1:0]
                                  : w_a - w_b;

    pl_modmul_seq #(
      .DATA_WID (W),
      .MODULUS  (M)
    ) u_mm (
      .clk      (clk),
      .reset    (reset),
      .start    (w_start),
      .step     (w_step),
      .int_mode ((i == 0) ? !rns_en : 1'b0),
      .a        (w_a),
      .b        (w_b),
      .acc      (w_mul[i])
    );
  end

  assign w_isum = {1'b0, op1[W-1:0]} + {1'b0, op2[W-1:0]};
  assign w_idif = {1'b0, op1[W-1:0]} - {1'b0, op2[W-1:0]};

  always_comb begin
    w_res_sc  = '0;
    w_res_mul = '0;
    w_cout_sc = 1'b0;
    if (r_rns) begin
      for (int i = 0; i < N; i++)
        w_res_mul[i*W +: W] = w_mul[i];
    end else begin
      w_res_mul[W-1:0] = w_mul[0];
    end
    if (rns_en) begin
      for (int i = 0; i < N; i++) begin
        case (op)
          OP_ADD:  w_res_sc[i*W +: W] = w_add[i];
          OP_SUB:  w_res_sc[i*W +: W] = w_sub[i];
          OP_PASS: w_res_sc[i*W +: W] = op1[i*W +: W];
          default: w_res_sc[i*W +: W] = op1[i*W +: W];
        endcase
      end
    end else begin
      case (op)
        OP_ADD: begin
          w_res_sc[W-1:0] = w_isum[W-1:0];
          w_cout_sc       = w_isum[W];
        end
        OP_SUB: begin
          w_res_sc[W-1:0] = w_idif[W-1:0];
          w_cout_sc       = w_idif[W];
        end
        OP_PASS: w_res_sc[W-1:0] = op1[W-1:0];
        default: w_res_sc[W-1:0] = op1[W-1:0];
      endcase
    end
  end

  // Flush beats a new load, which beats a drain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid     <= 1'b0;
      out_result    <= '0;
      out_dest_addr <= '0;
      out_cout      <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (w_accept && !w_is_mul) begin
      out_valid     <= 1'b1;
      out_result    <= w_res_sc;
      out_dest_addr <= dest_addr;
      out_cout      <= w_cout_sc;
    end else if (w_done) begin
      out_valid     <= 1'b1;
      out_result    <= w_res_mul;
      out_dest_addr <= r_dest;
      out_cout      <= 1'b0;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pl_ex_mc.sv
// Scoreboard bench for pl_ex_mc (2 domains, moduli 251/256).
// Expected results are queued at drive time, popped on output.
module tb_pl_ex_mc;
  import pl_ex_pkg::*;

  localparam int W  = 8;
  localparam int N  = 2;
  localparam int DW = N * W;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [2:0]    op = 3'd0;
  logic          rns_en = 1'b0;
  logic [DW-1:0] op1 = '0;
  logic [DW-1:0] op2 = '0;
  logic [3:0]    dest_addr = '0;
  logic          flush = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [DW-1:0] out_result;
  logic [3:0]    out_dest_addr;
  logic          out_cout;
  logic          busy;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [DW-1:0] res;
    logic [3:0]    dest;
    logic          cout;
  } exp_t;

  exp_t sbq[$];

  pl_ex_mc #(
    .NUM_DOMAINS (N),
    .DATA_WID    (W),
    .MODULI      ({9'd256, 9'd251})
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .op            (op),
    .rns_en        (rns_en),
    .op1           (op1),
    .op2           (op2),
    .dest_addr     (dest_addr),
    .flush         (flush),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_result    (out_result),
    .out_dest_addr (out_dest_addr),
    .out_cout      (out_cout),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic exp_t model(
    input logic [2:0] o, input logic r,
    input logic [DW-1:0] a, input logic [DW-1:0] b,
    input logic [3:0] d);
    exp_t e;
    int m, x, y, v;
    e.res  = '0;
    e.dest = d;
    e.cout = 1'b0;
    for (int i = 0; i < N; i++) begin
      m = (r && i == 0) ? 251 : 256;
      x = int'(a[i*W +: W]);
      y = int'(b[i*W +: W]);
      if (r || i == 0) begin
        case (o)
          3'd0: begin v = x + y; if (!r) e.cout = (v > 255); end
          3'd1: begin v = x - y; if (!r) e.cout = (x < y); end
          3'd2: v = x * y;
          default: v = x;
        endcase
        v = ((v % m) + m) % m;
        e.res[i*W +: W] = v[W-1:0];
      end
    end
    return e;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Offer one op for one edge and queue what it should give.
  task automatic offer(input logic [2:0] o, input logic r,
                       input logic [DW-1:0] a,
                       input logic [DW-1:0] b,
                       input logic [3:0] d, input exp_t e);
    op = o; rns_en = r; op1 = a; op2 = b; dest_addr = d;
    in_valid = 1'b1;
    sbq.push_back(e);
    cyc();
    in_valid = 1'b0;
  endtask

  task automatic wait_out(input int lim, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < lim; k++) begin
      if (out_valid) begin
        ok = 1'b1;
        break;
      end
      cyc();
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #1 reset = 1'b1;
    #1;
    n_cmp++;
    if ({out_valid, busy, out_cout, out_dest_addr, out_result} !== '0) begin
      n_bad++;
      $display("FAIL reset_async: got v=%b b=%b c=%b d=%h r=%h want all 0",
               out_valid, busy, out_cout, out_dest_addr, out_result);
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_ready: got in_ready=%b want 1", in_ready);
    end
    cyc();
  endtask

  task automatic test_add_rns();
    exp_t e;
    offer(OP_ADD, 1'b1, {8'd200, 8'd200}, {8'd100, 8'd100}, 4'h5,
          '{res: {8'd44, 8'd49}, dest: 4'h5, cout: 1'b0});
    e = sbq.pop_front();
    n_cmp++;
    if (out_valid !== 1'b1 || out_result !== e.res ||
        out_cout !== e.cout || out_dest_addr !== e.dest) begin
      n_bad++;
      $display("FAIL add_rns: got v=%b r=%h c=%b d=%h want v=1 r=%h c=%b d=%h",
               out_valid, out_result, out_cout, out_dest_addr,
               e.res, e.cout, e.dest);
    end
    cyc();
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL add_drain: got out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic test_sub_rns();
    exp_t e;
    offer(OP_SUB, 1'b1, {8'd5, 8'd5}, {8'd10, 8'd10}, 4'hA,
          '{res: {8'd251, 8'd246}, dest: 4'hA, cout: 1'b0});
    e = sbq.pop_front();
    n_cmp++;
    if (out_valid !== 1'b1 || out_result !== e.res ||
        out_cout !== e.cout || out_dest_addr !== e.dest) begin
      n_bad++;
      $display("FAIL sub_rns: got v=%b r=%h c=%b d=%h want v=1 r=%h c=%b d=%h",
               out_valid, out_result, out_cout, out_dest_addr,
               e.res, e.cout, e.dest);
    end
    cyc();
  endtask

  task automatic test_mul_rns();
    exp_t e;
    offer(OP_MUL, 1'b1, {8'd20, 8'd20}, {8'd30, 8'd30}, 4'h9,
          '{res: {8'd88, 8'd98}, dest: 4'h9, cout: 1'b0});
    for (int k = 0; k < W; k++) begin
      n_cmp++;
      if ({busy, in_ready, out_valid} !== 3'b100) begin
        n_bad++;
        $display("FAIL mul_iter%0d: got busy=%b in_ready=%b out_valid=%b want 1 0 0",
                 k, busy, in_ready, out_valid);
      end
      cyc();
    end
    e = sbq.pop_front();
    n_cmp++;
    if (out_valid !== 1'b1 || busy !== 1'b0 || out_result !== e.res ||
        out_cout !== e.cout || out_dest_addr !== e.dest) begin
      n_bad++;
      $display("FAIL mul_rns: got v=%b busy=%b r=%h c=%b d=%h want v=1 busy=0 r=%h c=%b d=%h",
               out_valid, busy, out_result, out_cout, out_dest_addr,
               e.res, e.cout, e.dest);
    end
    cyc();
  endtask

  task automatic test_int();
    logic [2:0] t_op [4];
    logic [7:0] t_a  [4];
    logic [7:0] t_b  [4];
    logic [7:0] t_r  [4];
    logic       t_c  [4];
    exp_t e;
    bit ok;
    t_op = '{OP_ADD, OP_SUB, OP_MUL, 3'd6};
    t_a  = '{8'd200, 8'd5, 8'd20, 8'd200};
    t_b  = '{8'd100, 8'd10, 8'd30, 8'd17};
    t_r  = '{8'd44, 8'd251, 8'd88, 8'd200};
    t_c  = '{1'b1, 1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 4; i++) begin
      offer(t_op[i], 1'b0, {8'hAB, t_a[i]}, {8'hCD, t_b[i]},
            4'(i + 1),
            '{res: {8'd0, t_r[i]}, dest: 4'(i + 1), cout: t_c[i]});
      wait_out(12, ok);
      e = sbq.pop_front();
      n_cmp++;
      if (!ok) begin
        n_bad++;
        $display("FAIL int%0d_timeout: got no out_valid want result %h", i, e.res);
      end else if (out_result !== e.res || out_cout !== e.cout ||
                   out_dest_addr !== e.dest) begin
        n_bad++;
        $display("FAIL int%0d: got r=%h c=%b d=%h want r=%h c=%b d=%h",
                 i, out_result, out_cout, out_dest_addr,
                 e.res, e.cout, e.dest);
      end
      cyc();
    end
  endtask

  task automatic test_backpressure();
    exp_t e;
    out_ready = 1'b0;
    offer(OP_ADD, 1'b1, {8'd1, 8'd250}, {8'd2, 8'd3}, 4'h7,
          '{res: {8'd3, 8'd2}, dest: 4'h7, cout: 1'b0});
    e = sbq[0];
    for (int k = 0; k < 3; k++) begin
      op = OP_SUB; rns_en = 1'b1; op1 = 16'h1234; op2 = 16'h0101;
      dest_addr = 4'hE; in_valid = 1'b1;
      #1;
      n_cmp++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_result !== e.res ||
          out_dest_addr !== e.dest || out_cout !== e.cout) begin
        n_bad++;
        $display("FAIL stall%0d: got rdy=%b v=%b r=%h d=%h c=%b want rdy=0 v=1 r=%h d=%h c=%b",
                 k, in_ready, out_valid, out_result, out_dest_addr, out_cout,
                 e.res, e.dest, e.cout);
      end
      cyc();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    void'(sbq.pop_front());
    cyc();
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL stall_release: got out_valid=%b want 0", out_valid);
    end
  endtask

  task automatic check_add_after(input string tag);
    exp_t e;
    offer(OP_ADD, 1'b1, {8'd17, 8'd240}, {8'd33, 8'd20}, 4'hC,
          model(OP_ADD, 1'b1, {8'd17, 8'd240}, {8'd33, 8'd20}, 4'hC));
    e = sbq.pop_front();
    n_cmp++;
    if (out_valid !== 1'b1 || out_result !== e.res ||
        out_dest_addr !== e.dest || out_cout !== e.cout) begin
      n_bad++;
      $display("FAIL %s_next_add: got v=%b r=%h d=%h c=%b want v=1 r=%h d=%h c=%b",
               tag, out_valid, out_result, out_dest_addr, out_cout,
               e.res, e.dest, e.cout);
    end
    cyc();
  endtask

  task automatic test_flush_mul();
    bit seen;
    offer(OP_MUL, 1'b1, {8'd20, 8'd20}, {8'd30, 8'd30}, 4'h3, '0);
    void'(sbq.pop_back());
    repeat (3) cyc();
    flush = 1'b1;
    op = OP_ADD; in_valid = 1'b1;
    cyc();
    flush = 1'b0; in_valid = 1'b0;
    n_cmp++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL flush_state: got busy=%b v=%b rdy=%b want 0 0 1",
               busy, out_valid, in_ready);
    end
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (out_valid) seen = 1'b1;
      cyc();
    end
    n_cmp++;
    if (seen !== 1'b0) begin
      n_bad++;
      $display("FAIL flush_quiet: got out_valid=1 after flush want 0");
    end
    check_add_after("flush");
  endtask

  task automatic test_reset_mid_mul();
    bit seen;
    offer(OP_MUL, 1'b1, {8'd7, 8'd9}, {8'd11, 8'd13}, 4'h6, '0);
    void'(sbq.pop_back());
    repeat (3) cyc();
    #2 reset = 1'b1;
    #1;
    n_cmp++;
    if ({busy, out_valid, out_cout, out_dest_addr, out_result} !== '0) begin
      n_bad++;
      $display("FAIL rst_mid: got busy=%b v=%b c=%b d=%h r=%h want all 0",
               busy, out_valid, out_cout, out_dest_addr, out_result);
    end
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL rst_mid_ready: got in_ready=%b want 1", in_ready);
    end
    cyc();
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (out_valid) seen = 1'b1;
      cyc();
    end
    n_cmp++;
    if (seen !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_mid_quiet: got out_valid=1 after reset want 0");
    end
    check_add_after("reset");
  endtask

  task automatic test_back_to_back();
    logic [2:0]    o;
    logic          r;
    logic [DW-1:0] a, b;
    exp_t e;
    for (int i = 0; i < 5; i++) begin
      o = 3'($urandom_range(0, 1)) | ((i == 2) ? 3'd3 : 3'd0);
      r = (i != 3);
      a = {8'($urandom_range(0, 255)), 8'($urandom_range(0, 250))};
      b = {8'($urandom_range(0, 255)), 8'($urandom_range(0, 250))};
      op = o; rns_en = r; op1 = a; op2 = b; dest_addr = 4'(i);
      in_valid = 1'b1;
      sbq.push_back(model(o, r, a, b, 4'(i)));
      cyc();
      e = sbq.pop_front();
      n_cmp++;
      if (out_valid !== 1'b1 || out_result !== e.res ||
          out_cout !== e.cout || out_dest_addr !== e.dest) begin
        n_bad++;
        $display("FAIL b2b%0d: got v=%b r=%h c=%b d=%h want v=1 r=%h c=%b d=%h",
                 i, out_valid, out_result, out_cout, out_dest_addr,
                 e.res, e.cout, e.dest);
      end
    end
    in_valid = 1'b0;
    cyc();
  endtask

  task automatic test_random();
    logic [2:0]    o;
    logic          r;
    logic [DW-1:0] a, b;
    exp_t e;
    bit ok;
    for (int i = 0; i < 40; i++) begin
      o = 3'($urandom_range(0, 7));
      r = 1'($urandom_range(0, 1));
      a = {8'($urandom_range(0, 255)),
           8'($urandom_range(0, r ? 250 : 255))};
      b = {8'($urandom_range(0, 255)),
           8'($urandom_range(0, r ? 250 : 255))};
      offer(o, r, a, b, 4'(i), model(o, r, a, b, 4'(i)));
      wait_out(12, ok);
      e = sbq.pop_front();
      n_cmp++;
      if (!ok) begin
        n_bad++;
        $display("FAIL rnd%0d_timeout: got no out_valid want r=%h", i, e.res);
      end else if (out_result !== e.res || out_cout !== e.cout ||
                   out_dest_addr !== e.dest) begin
        n_bad++;
        $display("FAIL rnd%0d op=%0d rns=%b a=%h b=%h: got r=%h c=%b d=%h want r=%h c=%b d=%h",
                 i, o, r, a, b, out_result, out_cout, out_dest_addr,
                 e.res, e.cout, e.dest);
      end
      cyc();
    end
  endtask

  initial begin
    test_reset();
    test_add_rns();
    test_sub_rns();
    test_mul_rns();
    test_int();
    test_backpressure();
    test_flush_mul();
    test_reset_mid_mul();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pl_ex_mc.md
PL_EX_MC -- requirements
Module: pl_ex_mc

Interface
REQ-001 SHALL have parameter NUM_DOMAINS, default 2, meaning the number of RNS domains (minimum 1).
REQ-002 SHALL have parameter DATA_WID, default 8, meaning the per-domain operand width.
REQ-003 SHALL have parameter MODULI, default {9'd256, 9'd251}, packed (DATA_WID+1) bits per domain with domain 0 in the LSBs, meaning the per-domain modulus (2 to 2^DATA_WID).
REQ-004 SHALL have ports: clk input 1, the single clock, with one clock for the whole block; reset input 1, asynchronous and active-high.
REQ-005 SHALL have in_valid input 1, meaning an operation is offered.
REQ-006 SHALL have in_ready output 1, meaning the block can accept an operation this cycle.
REQ-007 SHALL have op input 3, the opcode: ADD=0, SUB=1, MUL=2, PASS=3 (op1 through); codes 4-7 are reserved and execute as PASS.
REQ-008 SHALL have rns_en input 1: 1 for per-domain modular operation, 0 for integer operation on domain 0.
REQ-009 SHALL have op1, op2 inputs, each NUM_DOMAINS*DATA_WID, domain i at [i*DATA_WID +: DATA_WID].
REQ-010 SHALL have dest_addr input 4, meaning {RNS file, reg[2:0]}, carried with the operation.
REQ-011 SHALL have flush input 1, meaning abort the in-flight operation and discard the output.
REQ-012 SHALL have out_valid output 1, out_ready input 1, out_result output NUM_DOMAINS*DATA_WID, out_dest_addr output 4, and out_cout output 1.
REQ-013 SHALL have busy output 1, high while a MUL is iterating.

Function
REQ-014 SHALL accept an operation on a rising edge where in_valid && in_ready && !flush.
REQ-015 SHALL drive in_ready = (state==IDLE) && (!out_valid || out_ready), combinationally.
REQ-016 SHALL produce ADD/SUB/PASS results in out_result with out_valid high from the accept edge onward (latency 1).
REQ-017 SHALL, for MUL, enter state MUL on the accept edge, iterate once per cycle for DATA_WID cycles, load the output on the final iteration edge (latency DATA_WID), and return to IDLE.
REQ-018 SHALL use exactly two FSM states: IDLE and MUL; busy = (state==MUL).
REQ-019 SHALL, when rns_en=1, compute domain i as (a+b) mod m_i, (a-b) mod m_i, or (a*b) mod m_i; operands are required reduced (<m_i), and unreduced operands give an unspecified result.
REQ-020 SHALL compute MUL MSB-first: acc <= (2*acc + b[k]*a) mod m_i, with acc cleared at accept, using no combinational multiplier.
REQ-021 SHALL, when rns_en=0, compute domain 0 modulo 2^DATA_WID, with out_cout = carry-out for ADD and borrow for SUB, and 0 for MUL/PASS.
REQ-022 SHALL, when rns_en=0, drive the other domains to 0.
REQ-023 SHALL drive out_cout = 0 when rns_en=1.
REQ-024 SHALL hold out_result, out_dest_addr and out_cout stable while out_valid && !out_ready.
REQ-025 SHALL clear out_valid on an edge with out_ready high and no new result loaded.
REQ-026 SHALL, on an edge with out_ready high and a new acceptance, keep out_valid high with the new contents (back-to-back throughput of 1 for single-cycle ops).
REQ-027 SHALL, on flush, clear out_valid, abandon a MUL (state to IDLE) and block acceptance that edge.
REQ-028 SHALL give flush priority over in_valid and out_ready.
REQ-029 SHALL make out_dest_addr equal to the dest_addr captured at accept.

Reset
REQ-030 SHALL, on reset assertion, immediately set state=IDLE, out_valid=0, out_result=0, out_dest_addr=0, out_cout=0, busy=0 and accumulators=0, independent of clk.
REQ-031 SHALL abort a MUL in progress on reset mid-operation, with no output produced after release.
REQ-032 SHALL permit in_ready high on the first edge after reset release.

Structure
REQ-033 SHALL put the opcode constants, state encoding and default MODULI in shared package pl_ex_pkg.
REQ-034 SHALL instantiate one sub-module pl_modmul_seq per domain via generate (parameter modulus, DATA_WID; start/a/b in, acc out).
REQ-035 SHALL implement integer mode as pl_modmul_seq instance 0 with modulus 2^DATA_WID.

Verification
REQ-036 SHALL cover: ADD, rns_en=1, op1={200,200}, op2={100,100} -> one cycle later out_result={44,49} (domain1, domain0), out_cout=0.
REQ-037 SHALL cover: SUB, rns_en=1, op1={5,5}, op2={10,10} -> {251,246}.
REQ-038 SHALL cover: MUL, rns_en=1, op1={20,20}, op2={30,30} -> busy for 8 cycles, in_ready=0 throughout, out_valid 8 cycles after accept with {88,98}.
REQ-039 SHALL cover: ADD, rns_en=0, op1[7:0]=200, op2[7:0]=100 -> {0,44}, out_cout=1.
REQ-040 SHALL cover: out_ready=0 for 3 cycles after an ADD result -> outputs stable and in_ready=0; out_ready=1 -> out_valid drops next edge.
REQ-041 SHALL cover: flush at MUL cycle 4, and separately reset asserted mid-MUL -> out_valid never rises for that op, state IDLE, and the next ADD executes correctly.
